// File: rtl/universal_shift_latch.sv
// universal_shift_latch
// WIDTH-bit register with a per-cycle operation chosen by mode:
//   hold, parallel load, serial shift left/right, rotate left/right, clear.
// Consecutive serial shifts (SHL/SHR, freely interleaved) are counted.
// Every WIDTH-th consecutive serial shift raises frame_done for one cycle,
// which marks that q holds a word assembled entirely from ser_in.
// Optional feature: define USL_PARITY_EN to add q_par, the registered
// even-parity bit of q.
// Reset is asynchronous and active-low (rst_n).

module universal_shift_latch #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             frame_done
`ifdef USL_PARITY_EN
    ,
    output logic             q_par
`endif
);

    // Operation encoding; 7 is reserved and treated as HOLD.
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_CLR  = 3'd6;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] data_q, data_d;
    logic             ser_out_q, ser_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_q, frame_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             is_serial;

    assign is_serial = (mode == MODE_SHL) || (mode == MODE_SHR);
    assign cnt_inc   = cnt_q + CNT_ONE;

    // Next data word and serial-out bit for the selected operation.
    always_comb begin
        data_d    = data_q;
        ser_out_d = ser_out_q;
        case (mode)
            MODE_LOAD: data_d = d;
            MODE_SHL: begin
                data_d    = {data_q[WIDTH-2:0], ser_in};
                ser_out_d = data_q[WIDTH-1];
            end
            MODE_SHR: begin
                data_d    = {ser_in, data_q[WIDTH-1:1]};
                ser_out_d = data_q[0];
            end
            MODE_ROL: begin
                data_d    = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                ser_out_d = data_q[WIDTH-1];
            end
            MODE_ROR: begin
                data_d    = {data_q[0], data_q[WIDTH-1:1]};
                ser_out_d = data_q[0];
            end
            MODE_CLR:  data_d = '0;
            MODE_HOLD: data_d = data_q;
            default:   data_d = data_q;
        endcase
    end

    // Frame counter: serial shifts advance it, anything else restarts the frame.
    // Reaching WIDTH wraps to zero on the same edge so the count never
    // exceeds WIDTH-1 between edges, and fires the one-cycle frame pulse.
    always_comb begin
        cnt_d   = '0;
        frame_d = 1'b0;
        if (is_serial) begin
            if (cnt_inc == CNT_FULL) begin
                cnt_d   = '0;
                frame_d = 1'b1;
            end else begin
                cnt_d   = cnt_inc;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            ser_out_q <= 1'b0;
            cnt_q     <= '0;
            frame_q   <= 1'b0;
        end else begin
            data_q    <= data_d;
            ser_out_q <= ser_out_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
        end
    end

    assign q          = data_q;
    assign ser_out    = ser_out_q;
    assign frame_done = frame_q;

`ifdef USL_PARITY_EN
    logic par_q;

    // Parity tracks the word being written so it lines up with q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^data_d;
        end
    end

    assign q_par = par_q;
`endif

endmodule

// File: tb/tb_universal_shift_latch.sv
// Testbench for universal_shift_latch (WIDTH=8).
// Directed vector table, hand-written frame/reset sequences, and randomized
// stimulus checked against an arithmetic reference model.
// Parity checks are active when USL_PARITY_EN is defined.

module tb_universal_shift_latch;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic [W-1:0] d = '0;
    logic         ser_in = 1'b0;
    logic [W-1:0] q;
    logic         ser_out;
    logic         frame_done;
`ifdef USL_PARITY_EN
    logic         q_par;
`endif

    universal_shift_latch #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .d          (d),
        .ser_in     (ser_in),
        .q          (q),
        .ser_out    (ser_out),
        .frame_done (frame_done)
`ifdef USL_PARITY_EN
        ,
        .q_par      (q_par)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock edge with the given inputs; returns sampled 1 time unit later.
    task automatic step(input logic [2:0] m, input logic [W-1:0] dv, input logic si);
        mode   = m;
        d      = dv;
        ser_in = si;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Word kept as an integer, shifts computed arithmetically; framing is
    // the length of the current run of serial shifts, a pulse every W.
    longint unsigned m_q;
    bit              m_so;
    int              m_run;
    bit              m_fd;
    localparam longint unsigned MOD = 64'd1 << W;

    function automatic void model_reset();
        m_q = 0; m_so = 0; m_run = 0; m_fd = 0;
    endfunction

    function automatic void model_step(input int m, input longint unsigned dv, input bit si);
        bit msb, lsb;
        msb = bit'((m_q >> (W - 1)) & 1);
        lsb = bit'(m_q & 1);
        case (m)
            1: m_q = dv % MOD;
            2: begin m_q = (m_q * 2 + si) % MOD;                 m_so = msb; end
            3: begin m_q = m_q / 2 + (si ? MOD / 2 : 0);         m_so = lsb; end
            4: begin m_q = (m_q * 2 + msb) % MOD;                m_so = msb; end
            5: begin m_q = m_q / 2 + (lsb ? MOD / 2 : 0);        m_so = lsb; end
            6: m_q = 0;
            default: ;
        endcase
        if (m == 2 || m == 3) begin
            m_run++;
            m_fd = (m_run % W) == 0;
        end else begin
            m_run = 0;
            m_fd  = 0;
        end
    endfunction

    typedef struct {
        logic [2:0]   mode;
        logic [W-1:0] d;
        logic         si;
        logic [W-1:0] q;
        logic         so;
        logic         fd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [7:0] bits;
        string nm;

        // Directed vectors applied back to back after reset.
        tbl[0]  = '{3'd1, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0}; // load
        tbl[1]  = '{3'd0, 8'hFF, 1'b0, 8'hA5, 1'b0, 1'b0}; // hold
        tbl[2]  = '{3'd7, 8'hFF, 1'b1, 8'hA5, 1'b0, 1'b0}; // reserved = hold
        tbl[3]  = '{3'd0, 8'hFF, 1'b1, 8'hA5, 1'b0, 1'b0}; // hold
        tbl[4]  = '{3'd2, 8'h00, 1'b1, 8'h4B, 1'b1, 1'b0}; // SHL
        tbl[5]  = '{3'd1, 8'h81, 1'b0, 8'h81, 1'b1, 1'b0}; // load keeps ser_out
        tbl[6]  = '{3'd3, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0}; // SHR
        tbl[7]  = '{3'd1, 8'h81, 1'b0, 8'h81, 1'b1, 1'b0}; // load
        tbl[8]  = '{3'd4, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0}; // ROL
        tbl[9]  = '{3'd6, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0}; // CLR
        tbl[10] = '{3'd5, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0}; // ROR of zero
        tbl[11] = '{3'd1, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0}; // load

        // ---------------- reset ----------------
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3'd1, 8'hFF, 1'b0);
        chk("pre_reset_load_q", q, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_q", q, 8'h00);
        chk("async_reset_ser_out", ser_out, 1'b0);
        chk("async_reset_frame_done", frame_done, 1'b0);
`ifdef USL_PARITY_EN
        chk("async_reset_q_par", q_par, 1'b0);
`endif
        $display("reset asserted mid-cycle: q=%0h ser_out=%0b frame_done=%0b", q, ser_out, frame_done);
        #2 rst_n = 1'b1;
        step(3'd0, 8'hFF, 1'b1);
        chk("reset_release_hold_q", q, 8'h00);
        $display("reset released, hold: q=%0h", q);

        // ---------------- table ----------------
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].mode, tbl[i].d, tbl[i].si);
            nm = $sformatf("vec%0d", i);
            chk({nm, "_q"}, q, tbl[i].q);
            chk({nm, "_ser_out"}, ser_out, tbl[i].so);
            chk({nm, "_frame_done"}, frame_done, tbl[i].fd);
            $display("vec %0d: mode=%0d d=%0h si=%0b -> q=%0h ser_out=%0b frame_done=%0b",
                     i, tbl[i].mode, tbl[i].d, tbl[i].si, q, ser_out, frame_done);
        end

        // ---------------- full frame ----------------
        step(3'd6, 8'h00, 1'b0);
        bits = 8'b10110010;
        for (int i = 0; i < 8; i++) begin
            step(3'd2, 8'h00, bits[7 - i]);
            chk($sformatf("frame1_shift%0d_frame_done", i + 1), frame_done, (i == 7) ? 1'b1 : 1'b0);
            $display("frame1 shift %0d: q=%0h frame_done=%0b", i + 1, q, frame_done);
        end
        chk("frame1_word", q, 8'hB2);
        for (int i = 0; i < 8; i++) begin
            step((i % 2 == 0) ? 3'd2 : 3'd3, 8'h00, 1'b1);
            chk($sformatf("frame2_shift%0d_frame_done", i + 1), frame_done, (i == 7) ? 1'b1 : 1'b0);
            $display("frame2 shift %0d: q=%0h frame_done=%0b", i + 1, q, frame_done);
        end
        step(3'd0, 8'h00, 1'b0);
        chk("frame_pulse_one_cycle", frame_done, 1'b0);

        // ---------------- interrupted by HOLD ----------------
        for (int i = 0; i < 5; i++) step(3'd2, 8'h00, 1'b1);
        step(3'd0, 8'h00, 1'b0);
        chk("hold_interrupt_frame_done", frame_done, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(3'd2, 8'h00, 1'b0);
            chk($sformatf("post_hold_shift%0d_frame_done", i + 1), frame_done, (i == 7) ? 1'b1 : 1'b0);
            $display("post-hold shift %0d: frame_done=%0b", i + 1, frame_done);
        end

        // ---------------- interrupted by reset ----------------
        for (int i = 0; i < 4; i++) step(3'd3, 8'h00, 1'b1);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(3'd2, 8'h00, 1'b1);
            chk($sformatf("post_reset_shift%0d_frame_done", i + 1), frame_done, (i == 7) ? 1'b1 : 1'b0);
            $display("post-reset shift %0d: frame_done=%0b", i + 1, frame_done);
        end
        chk("post_reset_word", q, 8'hFF);

`ifdef USL_PARITY_EN
        // ---------------- parity ----------------
        step(3'd1, 8'h07, 1'b0);
        chk("parity_07", q_par, 1'b1);
        step(3'd1, 8'hA5, 1'b0);
        chk("parity_A5", q_par, 1'b0);
        step(3'd2, 8'h00, 1'b1);
        chk("parity_shl_q", q, 8'h4B);
        chk("parity_shl_q_par", q_par, 1'b0);
        $display("parity sequence done: q=%0h q_par=%0b", q, q_par);
`endif

        // ---------------- randomized vs model ----------------
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 600; i++) begin
            logic [2:0]   rm;
            logic [W-1:0] rd;
            logic         rs;
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
                model_reset();
            end
            // Favour serial shifts so full frames actually occur.
            rm = ($urandom_range(0, 9) < 6) ? 3'($urandom_range(2, 3)) : 3'($urandom_range(0, 7));
            rd = W'($urandom);
            rs = 1'($urandom);
            step(rm, rd, rs);
            model_step(int'(rm), longint'(rd), rs);
            chk($sformatf("rand%0d_q", i), q, m_q);
            chk($sformatf("rand%0d_ser_out", i), ser_out, m_so);
            chk($sformatf("rand%0d_frame_done", i), frame_done, m_fd);
`ifdef USL_PARITY_EN
            chk($sformatf("rand%0d_q_par", i), q_par, $countones(m_q) % 2);
`endif
            $display("rand %0d: mode=%0d d=%0h si=%0b -> q=%0h ser_out=%0b frame_done=%0b",
                     i, rm, rd, rs, q, ser_out, frame_done);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
